tl_ul_sram_slave: RTL and testbench
===================================

Name: tl_ul_sram_slave

Overview:
- TileLink-UL single-beat memory slave; sits directly downstream of the fragmenter coupler and consumes its A channel (size ≤ 8 bytes, 9-bit source).
- Serves PutFullData, PutPartialData and Get from an internal byte-maskable synchronous SRAM.
- Returns AccessAck / AccessAckData on the D channel through a credit-limited response FIFO, so back-pressure never drops a response.

Parameters:
- ADDR_W, 26, A-channel address width
- DATA_W, 64, beat width; mask width is DATA_W/8
- SOURCE_W, 9, source ID width
- SIZE_W, 2, size field width (log2 bytes)
- MEM_DEPTH, 1024, SRAM words
- BASE_ADDR, 26'h0, byte address of word 0; must be DATA_W/8 aligned
- RESP_DEPTH, 3, response FIFO entries; minimum 3 for full throughput

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- a_ready  out  1  A channel ready
- a_valid  in  1  A channel valid
- a_bits_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get
- a_bits_size  in  SIZE_W  log2 bytes
- a_bits_source  in  SOURCE_W  request ID
- a_bits_address  in  ADDR_W  byte address
- a_bits_mask  in  DATA_W/8  byte lanes
- a_bits_data  in  DATA_W  write data
- d_ready  in  1  D channel ready
- d_valid  out  1  D channel valid
- d_bits_opcode  out  3  0=AccessAck, 1=AccessAckData
- d_bits_size  out  SIZE_W  echo of a_bits_size
- d_bits_source  out  SOURCE_W  echo of a_bits_source
- d_bits_data  out  DATA_W  read data; 0 for AccessAck

Behaviour:
- Reset (reset=0, async):
  - a_ready=0, d_valid=0, d_bits_*=0.
  - FIFO count=0, inflight=0.
  - SRAM contents are not reset.
  - a_ready may rise on the first clock edge after release.
- Reset mid-operation: all queued and in-flight responses are discarded. An in-flight Get's SRAM read is squashed. A write issued in the edge coinciding with reset assertion is not guaranteed.
- Accept rule:
  - Fire = a_valid & a_ready.
  - a_ready = (count + inflight) < RESP_DEPTH, from registered state only; no combinational path from d_ready or a_valid.
- Stage 0 (fire cycle):
  - Decode word = (address - BASE_ADDR) >> log2(DATA_W/8); in_range = address ≥ BASE_ADDR and word < MEM_DEPTH.
  - Put & in_range: write enabled lanes of a_bits_data; mask=0 writes nothing.
  - Get & in_range: read issued; mask ignored.
  - Latch inflight=1 with opcode class, size, source and in_range.
- Stage 1 (next cycle): push {opcode, size, source, data} into FIFO.
  - Get in range: data = SRAM read data.
  - Get out of range: data = 0.
  - Put: AccessAck, data = 0.
  - Illegal opcode (anything except 0/1/4): no SRAM access; AccessAck, data 0.
- Latency: first D valid 2 cycles after A fire with empty FIFO; sustained 1 beat/cycle when d_ready=1.
- D channel:
  - d_valid = count≠0; head entry is held stable while d_valid & !d_ready.
  - Pop on d_valid & d_ready.
  - Push and pop in the same cycle leave count unchanged; push into an empty FIFO is not bypassed.
- Ordering: responses strictly in acceptance order.
- Hazards:
  - Write followed by read of the same word on the next fire returns the new data (SRAM write-first across cycles).
  - A Get never overlaps its own cycle with a Put.
- The credit rule guarantees the FIFO never overflows; underflow is impossible because pop is gated by d_valid.

Optional Feature:
- Macro SRAM_SLAVE_ERR_CNT_EN.
- Defined:
  - Adds output err_count [15:0], reset to 0.
  - Increments by 1 on each fired request that is an illegal opcode or out of range.
  - Saturates at 16'hFFFF.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package tl_ul_pkg:
  - opcode constants PUT_FULL=0, PUT_PARTIAL=1, GET=4, ACCESS_ACK=0, ACCESS_ACK_DATA=1;
  - typedef d_resp_t {opcode, size, source, data}.
- One sub-module tl_sram_array: MEM_DEPTH × DATA_W, 1-cycle synchronous read, per-byte write enables, no reset.

Test Plan:
- PutFull addr 0x40, mask 0xFF, data 0x1122334455667788, source 0x1A5, then Get 0x40 source 0x003 -> AccessAck source 0x1A5 at fire+2, then AccessAckData data 0x1122334455667788 source 0x003.
- PutPartial addr 0x40, mask 0x0F, data 0xFFFFFFFF_AAAAAAAA, then Get -> data 0x11223344_AAAAAAAA.
- Back-to-back 8 Gets, d_ready=1 throughout -> 8 in-order AccessAckData on consecutive cycles, a_ready never drops.
- d_ready=0 with a_valid=1 continuously -> exactly 3 fires, then a_ready=0; d stays stable; d_ready=1 -> drain in order, a_ready returns.
- Get addr BASE_ADDR+MEM_DEPTH*8; opcode 2 -> AccessAckData data 0; AccessAck; err_count=2 when macro defined.
- reset=0 pulse with 2 queued responses -> d_valid=0 immediately; no stale responses after release.

Source files
------------

// File: rtl/tl_ul_pkg.sv
// TileLink-UL constants and the D-channel response record shared by the SRAM slave.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   PUT_FULL / PUT_PARTIAL / GET         A-channel opcodes served by the slave
//   ACCESS_ACK / ACCESS_ACK_DATA         D-channel opcodes returned by the slave
//   d_resp_t                             one queued D-channel beat {opcode, size, source, data}
package tl_ul_pkg;

  // Field widths of a queued response; the slave's SIZE_W/SOURCE_W/DATA_W
  // parameters are expected to match these.
  localparam int TL_SIZE_W   = 2;
  localparam int TL_SOURCE_W = 9;
  localparam int TL_DATA_W   = 64;

  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] GET             = 3'd4;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [TL_SIZE_W-1:0]   size;
    logic [TL_SOURCE_W-1:0] source;
    logic [TL_DATA_W-1:0]   data;
  } d_resp_t;

endpackage

// File: rtl/tl_sram_array.sv
// Single-port word SRAM with per-byte write enables and a registered read port.
// Latency: read data valid one cycle after i_re; writes land on the same edge.
// Backpressure: none; the caller never issues a read and a write in the same cycle.
//
// Ports:
//   clock            clock (no reset; contents power up undefined)
//   i_we, i_be       write strobe and byte-lane enables
//   i_re             read strobe; o_rdata updates on the next edge and otherwise holds
//   i_idx            word index shared by read and write
//   i_wdata, o_rdata write / read data
module tl_sram_array #(
  parameter int DATA_W    = 64,
  parameter int MEM_DEPTH = 1024,
  localparam int IDX_W    = $clog2(MEM_DEPTH),
  localparam int BE_W     = DATA_W / 8
) (
  input  logic              clock,
  input  logic              i_we,
  input  logic [BE_W-1:0]   i_be,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/tl_ul_sram_slave.sv
// TileLink-UL single-beat slave serving PutFull/PutPartial/Get from a byte-maskable SRAM.
// Latency: D valid 2 cycles after A fire into an empty response queue; 1 beat/cycle sustained.
// Backpressure: a_ready is credit-based (queued + in-flight < RESP_DEPTH), so d_ready stalls never drop a response.
//
// Optional build macro SRAM_SLAVE_ERR_CNT_EN adds err_count[15:0]: saturating count of
// accepted requests with an illegal opcode or an out-of-range address.
//
// Ports:
//   clock, reset                 clock; asynchronous active-low reset
//   a_valid/a_ready, a_bits_*    A channel: opcode, size, source, address, mask, data
//   d_valid/d_ready, d_bits_*    D channel: opcode, size, source, data (0 unless AccessAckData in range)
//   err_count                    error counter (only with SRAM_SLAVE_ERR_CNT_EN)
module tl_ul_sram_slave
  import tl_ul_pkg::*;
#(
  parameter int                ADDR_W     = 26,
  parameter int                DATA_W     = 64,
  parameter int                SOURCE_W   = 9,
  parameter int                SIZE_W     = 2,
  parameter int                MEM_DEPTH  = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                RESP_DEPTH = 3
) (
  input  logic                clock,
  input  logic                reset,
  output logic                a_ready,
  input  logic                a_valid,
  input  logic [2:0]          a_bits_opcode,
  input  logic [SIZE_W-1:0]   a_bits_size,
  input  logic [SOURCE_W-1:0] a_bits_source,
  input  logic [ADDR_W-1:0]   a_bits_address,
  input  logic [DATA_W/8-1:0] a_bits_mask,
  input  logic [DATA_W-1:0]   a_bits_data,
  input  logic                d_ready,
  output logic                d_valid,
  output logic [2:0]          d_bits_opcode,
  output logic [SIZE_W-1:0]   d_bits_size,
  output logic [SOURCE_W-1:0] d_bits_source,
  output logic [DATA_W-1:0]   d_bits_data
`ifdef SRAM_SLAVE_ERR_CNT_EN
  ,
  output logic [15:0]         err_count
`endif
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);

  // ---------------- Stage 0: decode and SRAM access on fire ----------------
  logic              w_fire;
  logic              w_is_put;
  logic              w_is_get;
  logic              w_in_range;
  logic              w_we;
  logic              w_re;
  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] w_word;
  logic [DATA_W-1:0] w_rdata;

  assign w_fire     = a_valid & a_ready;
  assign w_off      = a_bits_address - BASE_ADDR;
  assign w_word     = w_off >> OFF_W;
  // The lower-bound compare also rejects addresses whose subtraction wrapped.
  assign w_in_range = (a_bits_address >= BASE_ADDR) && (w_word < DEPTH_A);
  assign w_is_put   = (a_bits_opcode == PUT_FULL) || (a_bits_opcode == PUT_PARTIAL);
  assign w_is_get   = (a_bits_opcode == GET);
  assign w_we       = w_fire & w_is_put & w_in_range;
  assign w_re       = w_fire & w_is_get & w_in_range;

  tl_sram_array #(
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_sram (
    .clock   (clock),
    .i_we    (w_we),
    .i_be    (a_bits_mask),
    .i_re    (w_re),
    .i_idx   (w_word[IDX_W-1:0]),
    .i_wdata (a_bits_data),
    .o_rdata (w_rdata)
  );

  // ---------------- Stage 1: in-flight slot, pushes into the queue ----------
  logic                r_inf_vld;
  logic                r_inf_rd;    // response data comes from the SRAM read port
  logic [2:0]          r_inf_op;
  logic [SIZE_W-1:0]   r_inf_size;
  logic [SOURCE_W-1:0] r_inf_source;
  d_resp_t             w_push_dat;

  always_comb begin
    w_push_dat        = '0;
    w_push_dat.opcode = r_inf_op;
    w_push_dat.size   = r_inf_size;
    w_push_dat.source = r_inf_source;
    w_push_dat.data   = r_inf_rd ? w_rdata : '0;
  end

  // ---------------- Response queue and credit ------------------------------
  d_resp_t          r_fifo [RESP_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_a_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_credit_ok;
  d_resp_t          w_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_push      = r_inf_vld;
  assign w_pop       = d_valid & d_ready;
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  // a_ready is the registered image of next-cycle credit, so the port itself
  // has no combinational path from d_ready or a_valid. One extra bit keeps
  // the sum from wrapping.
  assign w_credit_ok = ({1'b0, w_count_nxt} + (CNT_W+1)'(w_fire)) < (CNT_W+1)'(RESP_DEPTH);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_a_ready    <= 1'b0;
      r_inf_vld    <= 1'b0;
      r_inf_rd     <= 1'b0;
      r_inf_op     <= ACCESS_ACK;
      r_inf_size   <= '0;
      r_inf_source <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
    end else begin
      r_a_ready <= w_credit_ok;
      r_inf_vld <= w_fire;
      r_inf_rd  <= w_re;
      if (w_fire) begin
        // Out-of-range Gets still answer AccessAckData (with zero data).
        r_inf_op     <= w_is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
        r_inf_size   <= a_bits_size;
        r_inf_source <= a_bits_source;
      end
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      r_count <= w_count_nxt;
    end
  end

  // Queue storage is never reset; entries are only visible while counted.
  always_ff @(posedge clock) begin
    if (w_push) r_fifo[r_wptr] <= w_push_dat;
  end

  assign a_ready       = r_a_ready;
  assign d_valid       = (r_count != '0);
  assign w_head        = d_valid ? r_fifo[r_rptr] : '0;
  assign d_bits_opcode = w_head.opcode;
  assign d_bits_size   = w_head.size;
  assign d_bits_source = w_head.source;
  assign d_bits_data   = w_head.data;

`ifdef SRAM_SLAVE_ERR_CNT_EN
  logic [15:0] r_err_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_err_count <= '0;
    end else if (w_fire && (!(w_is_put || w_is_get) || !w_in_range) &&
                 (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_tl_ul_sram_slave.sv
module tb_tl_ul_sram_slave;

  localparam int          MEM_DEPTH = 1024;
  localparam logic [25:0] BASE_ADDR = 26'h0;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        a_ready;
  logic        a_valid;
  logic [2:0]  a_bits_opcode;
  logic [1:0]  a_bits_size;
  logic [8:0]  a_bits_source;
  logic [25:0] a_bits_address;
  logic [7:0]  a_bits_mask;
  logic [63:0] a_bits_data;
  logic        d_ready;
  logic        d_valid;
  logic [2:0]  d_bits_opcode;
  logic [1:0]  d_bits_size;
  logic [8:0]  d_bits_source;
  logic [63:0] d_bits_data;
`ifdef SRAM_SLAVE_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  always #5 clock = ~clock;

  tl_ul_sram_slave #(
    .ADDR_W(26), .DATA_W(64), .SOURCE_W(9), .SIZE_W(2),
    .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR), .RESP_DEPTH(3)
  ) dut (
    .clock(clock), .reset(reset),
    .a_ready(a_ready), .a_valid(a_valid), .a_bits_opcode(a_bits_opcode),
    .a_bits_size(a_bits_size), .a_bits_source(a_bits_source),
    .a_bits_address(a_bits_address), .a_bits_mask(a_bits_mask), .a_bits_data(a_bits_data),
    .d_ready(d_ready), .d_valid(d_valid), .d_bits_opcode(d_bits_opcode),
    .d_bits_size(d_bits_size), .d_bits_source(d_bits_source), .d_bits_data(d_bits_data)
`ifdef SRAM_SLAVE_ERR_CNT_EN
    , .err_count(err_count)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_pops = 0;
  int stalls = 0;
  int model_errs = 0;
  logic [63:0] last_d = '0;
  int pop_cyc[$];

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [8:0]  src;
    logic [63:0] data;
  } exp_t;
  exp_t expq[$];
  logic [63:0] model_mem [int];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Reference: a word-addressed memory plus an in-order queue of expected beats.
  function automatic void model_accept();
    exp_t e;
    longint unsigned addr;
    longint unsigned word;
    logic [63:0] w;
    bit inr;
    bit legal;
    addr   = longint'(a_bits_address);
    inr    = (addr >= longint'(BASE_ADDR)) && ((addr - longint'(BASE_ADDR)) / 8 < MEM_DEPTH);
    word   = (addr - longint'(BASE_ADDR)) / 8;
    e.size = a_bits_size;
    e.src  = a_bits_source;
    e.op   = 3'd0;
    e.data = 64'd0;
    legal  = 1'b1;
    case (a_bits_opcode)
      3'd0, 3'd1: if (inr) begin
        w = model_mem[int'(word)];
        for (int b = 0; b < 8; b++) if (a_bits_mask[b]) w[8*b +: 8] = a_bits_data[8*b +: 8];
        model_mem[int'(word)] = w;
      end
      3'd4: begin
        e.op = 3'd1;
        if (inr) e.data = model_mem[int'(word)];
      end
      default: legal = 1'b0;
    endcase
    if (!legal || !inr) model_errs++;
    expq.push_back(e);
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard: handshakes sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (reset) begin
      if (d_valid && d_ready) begin
        if (expq.size() == 0) begin
          chk("d_spurious", 64'(d_bits_source), 64'hDEAD);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("d_hdr", 64'({d_bits_opcode, d_bits_size, d_bits_source}), 64'({e.op, e.size, e.src}));
          chk("d_data", d_bits_data, e.data);
        end
        last_d = d_bits_data;
        n_pops++;
        pop_cyc.push_back(cyc);
      end
      if (a_valid && a_ready) model_accept();
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [25:0] addr, input logic [7:0] mask,
                      input logic [63:0] data, input logic [8:0] src, input logic [1:0] size);
    int n;
    n = 0;
    a_valid = 1'b1; a_bits_opcode = op; a_bits_address = addr; a_bits_mask = mask;
    a_bits_data = data; a_bits_source = src; a_bits_size = size;
    @(negedge clock);
    while (!a_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!a_ready) chk("a_ready_timeout", 64'(a_ready), 64'd1);
    stalls += n;
    @(posedge clock);
    #1;
    a_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clock);
    while ((expq.size() != 0 || d_valid) && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("drain_left", 64'(expq.size()), 64'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [63:0] snap_dat;
    logic [8:0]  snap_src;
    int nf;
    int p0;
    int st0;
    int r;
    bit acc;

    a_valid = 0; a_bits_opcode = 0; a_bits_size = 0; a_bits_source = 0;
    a_bits_address = 0; a_bits_mask = 0; a_bits_data = 0; d_ready = 0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    chk("rst_d_valid", 64'(d_valid), 64'd0);
    chk("rst_d_hdr", 64'({d_bits_opcode, d_bits_size, d_bits_source}), 64'd0);
    chk("rst_d_data", d_bits_data, 64'd0);
`ifdef SRAM_SLAVE_ERR_CNT_EN
    chk("rst_err_count", 64'(err_count), 64'd0);
`endif
    step();
    reset = 1'b1;
    #1 chk("rel_a_ready_low", 64'(a_ready), 64'd0);
    step();
    @(negedge clock);
    chk("a_ready_up", 64'(a_ready), 64'd1);
    step();
    d_ready = 1'b1;

    // Give words 0..15 known contents
    for (int w = 0; w < 16; w++) send(3'd0, 26'(w * 8), 8'hFF, {$urandom(), $urandom()}, 9'(w), 2'd3);
    wait_drain();

    // PutFull then Get, with first-beat latency
    send(3'd0, 26'h40, 8'hFF, 64'h1122334455667788, 9'h1A5, 2'd3);
    @(negedge clock);
    chk("t1_lat1_dvalid", 64'(d_valid), 64'd0);
    @(negedge clock);
    chk("t1_lat2_dvalid", 64'(d_valid), 64'd1);
    chk("t1_opcode", 64'(d_bits_opcode), 64'd0);
    chk("t1_source", 64'(d_bits_source), 64'h1A5);
    step();
    send(3'd4, 26'h40, 8'h00, 64'd0, 9'h003, 2'd3);
    wait_drain();
    chk("t1_get_data", last_d, 64'h1122334455667788);

    // PutPartial low lanes, then Get (mask ignored on Get)
    send(3'd1, 26'h40, 8'h0F, 64'hFFFFFFFF_AAAAAAAA, 9'h011, 2'd2);
    send(3'd4, 26'h40, 8'hFF, 64'd0, 9'h012, 2'd3);
    wait_drain();
    chk("t2_get_data", last_d, 64'h11223344_AAAAAAAA);

    // 8 back-to-back Gets
    st0 = stalls;
    p0  = n_pops;
    for (int i = 0; i < 8; i++) send(3'd4, 26'($urandom_range(0, 15) * 8), 8'h00, 64'd0, 9'($urandom_range(0, 511)), 2'd3);
    wait_drain();
    chk("t3_stalls", 64'(stalls - st0), 64'd0);
    chk("t3_pops", 64'(n_pops - p0), 64'd8);
    chk("t3_span", 64'(pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-8]), 64'd7);

    // d_ready low with a_valid held high: credit allows exactly 3 fires
    d_ready = 1'b0;
    nf = 0;
    snap_dat = '0;
    snap_src = '0;
    a_valid = 1'b1; a_bits_opcode = 3'd4; a_bits_mask = 8'h00; a_bits_data = 64'd0; a_bits_size = 2'd3;
    a_bits_source = 9'd32; a_bits_address = 26'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      acc = a_ready;
      if (acc) nf++;
      if (i == 4) begin
        snap_src = d_bits_source;
        snap_dat = d_bits_data;
      end
      @(posedge clock);
      #1;
      if (acc) begin
        a_bits_source  = 9'(33 + i);
        a_bits_address = 26'((i + 1) * 8);
      end
    end
    a_valid = 1'b0;
    @(negedge clock);
    chk("t4_fires", 64'(nf), 64'd3);
    chk("t4_a_ready_low", 64'(a_ready), 64'd0);
    chk("t4_d_valid", 64'(d_valid), 64'd1);
    chk("t4_head_src", 64'(d_bits_source), 64'd32);
    chk("t4_hold_src", 64'(d_bits_source), 64'(snap_src));
    chk("t4_hold_data", d_bits_data, snap_dat);
    step();
    d_ready = 1'b1;
    wait_drain();
    @(negedge clock);
    chk("t4_a_ready_back", 64'(a_ready), 64'd1);
    step();

    // Out-of-range Get and illegal opcode
    send(3'd4, BASE_ADDR + 26'(MEM_DEPTH * 8), 8'h00, 64'd0, 9'h0B0, 2'd3);
    wait_drain();
    chk("t5_oor_data", last_d, 64'd0);
    send(3'd2, 26'h40, 8'hFF, 64'hDEADBEEF_CAFEF00D, 9'h0B1, 2'd3);
    send(3'd4, 26'h40, 8'h00, 64'd0, 9'h0B2, 2'd3);
    wait_drain();
    chk("t5_illegal_nowrite", last_d, 64'h11223344_AAAAAAAA);
`ifdef SRAM_SLAVE_ERR_CNT_EN
    chk("t5_err_count", 64'(err_count), 64'd2);
`endif

    // Reset with two queued responses
    d_ready = 1'b0;
    send(3'd4, 26'h40, 8'h00, 64'd0, 9'h0C0, 2'd3);
    send(3'd4, 26'h48, 8'h00, 64'd0, 9'h0C1, 2'd3);
    step();
    chk("t6_pre_dvalid", 64'(d_valid), 64'd1);
    reset = 1'b0;
    #1;
    chk("t6_rst_dvalid", 64'(d_valid), 64'd0);
    chk("t6_rst_a_ready", 64'(a_ready), 64'd0);
    chk("t6_rst_data", d_bits_data, 64'd0);
    expq.delete();
    model_errs = 0;
    step();
    step();
    reset = 1'b1;
    d_ready = 1'b1;
    p0 = n_pops;
    repeat (10) step();
    @(negedge clock);
    chk("t6_no_stale", 64'(n_pops - p0), 64'd0);
    chk("t6_dvalid_idle", 64'(d_valid), 64'd0);
    chk("t6_a_ready", 64'(a_ready), 64'd1);
    step();

    // Randomized traffic with random d_ready
    for (int c = 0; c < 800; c++) begin
      if (!a_valid && $urandom_range(0, 3) != 0) begin
        r = int'($urandom_range(0, 15));
        if (r < 4)        a_bits_opcode = 3'd0;
        else if (r < 8)   a_bits_opcode = 3'd1;
        else if (r < 14)  a_bits_opcode = 3'd4;
        else if (r == 14) a_bits_opcode = 3'd2;
        else              a_bits_opcode = 3'd6;
        if ($urandom_range(0, 7) == 0)
          a_bits_address = BASE_ADDR + 26'(MEM_DEPTH * 8 + $urandom_range(0, 1 << 20));
        else
          a_bits_address = BASE_ADDR + 26'($urandom_range(0, 15) * 8 + $urandom_range(0, 7));
        a_bits_mask   = 8'($urandom_range(0, 255));
        a_bits_data   = {$urandom(), $urandom()};
        a_bits_source = 9'($urandom_range(0, 511));
        a_bits_size   = 2'($urandom_range(0, 3));
        a_valid = 1'b1;
      end
      d_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      acc = a_valid && a_ready;
      @(posedge clock);
      #1;
      if (acc) a_valid = 1'b0;
    end
    a_valid = 1'b0;
    d_ready = 1'b1;
    wait_drain();
`ifdef SRAM_SLAVE_ERR_CNT_EN
    chk("rand_err_count", 64'(err_count), 64'(model_errs));
`endif
    chk("end_dvalid", 64'(d_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
